instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Per-core instruction fetch stage that sits directly upstream of the instruction RAM and downstream-feeds the decoder. It owns the program counter, drives the RAM address bus and read strobe, captures each returned word into a single-entry instruction register, and hands it to decode over a valid/ready handshake. It supports a redirect (branch/jump) input and stops itself on a halt opcode.

## Interface
- ADDR_W, 16, PC / RAM address width
- DATA_W, 16, instruction width
- PC_INC, 1, PC increment per fetched instruction (modulo 2^ADDR_W)
- OPC_W, 4, opcode field width, taken from ir[DATA_W-1 -: OPC_W]
- HALT_OPC, 4'hF, opcode that terminates fetching
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse: begin fetching at start_pc (honoured in IDLE/HALT only)
- start_pc  in  ADDR_W  first fetch address
- pc_load  in  1  redirect request (honoured in FETCH only)
- pc_target  in  ADDR_W  redirect address
- ram_addr  out  ADDR_W  to RAM ADDBUS; always equals pc
- ram_rd  out  1  to RAM RD
- ram_data  in  DATA_W  from RAM DATAOUT; valid in the same cycle ram_addr/ram_rd are presented
- ir  out  DATA_W  fetched instruction
- ir_pc  out  ADDR_W  address ir was fetched from
- ir_valid  out  1  ir holds an unconsumed instruction
- ir_ready  in  1  decoder accepts ir this cycle
- busy  out  1  state is FETCH or DRAIN
- halted  out  1  state is HALT

## Operation
- States: IDLE, FETCH, DRAIN, HALT.
- IDLE/HALT + start: pc<=start_pc, ir_valid<=0, ->FETCH. start in FETCH/DRAIN ignored.
- ram_rd = (state==FETCH) && (!ir_valid || ir_ready). Combinational.
- FETCH, edge with pc_load=1: pc<=pc_target, ir_valid<=0 (flush, including an ir the decoder accepted that edge), no capture. pc_load has priority over capture and halt detection.
- FETCH, edge with ram_rd=1 and pc_load=0: ir<=ram_data, ir_pc<=pc, ir_valid<=1, pc<=pc+PC_INC (wraps 0xFFFF->0x0000 for ADDR_W=16). If ram_data opcode==HALT_OPC: pc not advanced, ->DRAIN.
- FETCH, ram_rd=0 (stall): all registers hold.
- Consumption: edge with ir_valid && ir_ready and no new capture -> ir_valid<=0.
- DRAIN: ram_rd=0; pc_load ignored; when halt word consumed -> ir_valid<=0, ->HALT.
- HALT: ram_rd=0, halted=1, waits for start.

## Timing
- Reset (async assert, sync use after deassert): state=IDLE, pc=0, ram_addr=0, ram_rd=0, ir=0, ir_pc=0, ir_valid=0, busy=0, halted=0.
- start sampled at edge E0 -> cycle after E0: ram_rd=1, ram_addr=start_pc -> ir_valid=1 after E1.
- Throughput 1 instruction/cycle while ir_ready=1.
- Redirect penalty: pc_load at edge E -> target word in ir after E+1.
- Stall: ir_valid held with ir_ready=0 -> ir, ir_pc, pc stable, ram_rd=0.
- Halt: halt word captured at edge E -> ram_rd=0 from cycle after E; halted=1 the cycle after halt word consumed.

## Structure
- Shared package fetch_pkg: state enum (IDLE, FETCH, DRAIN, HALT), OPC_W, HALT_OPC default, opcode-extract function.
- Single module. PC and instruction register are inline; no sub-module is natural.

## Test plan
RAM model: combinational, mem[a]=16'h0100+a, mem[16'h0020]=16'hF000, mem[16'hFFFF]=16'h0ABC.
- Reset then start, start_pc=0x0010, ir_ready=1 -> ir/ir_pc: 0x0110/0x10, 0x0111/0x11, ... one per cycle; after 0x20 captured ir=0xF000, next cycle ram_rd=0, halted=1 one cycle later.
- Stall: ir_ready=0 for 3 cycles after first capture -> ir=0x0110 held, pc=0x11, ram_rd=0; release -> 0x0111 next.
- Redirect: pc_load=1, pc_target=0x0005 while fetching 0x12 -> ir_valid=0 next cycle, then ir=0x0105, ir_pc=0x05.
- Wrap: start_pc=0xFFFF -> ir=0x0ABC, ir_pc=0xFFFF, then ir_pc=0x0000, ir=0x0100.
- Simultaneous pc_load and halt word at ram_data -> redirect wins, no DRAIN, busy stays 1.
- rst_n asserted mid-FETCH with ir_valid=1 -> all outputs immediately to reset values; start after release resumes normally.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM states,
// default opcode geometry and a width-agnostic opcode extractor.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    localparam int         OPC_W_DEF    = 4;
    localparam logic [3:0] HALT_OPC_DEF = 4'hF;

    // Top opc_w bits of a data_w-wide word, returned zero-extended to 32 bits.
    function automatic logic [31:0] opcode_field(input logic [31:0] word,
                                                 input int data_w,
                                                 input int opc_w);
        logic [31:0] mask;
        mask = (32'd1 << opc_w) - 32'd1;
        return (word >> (data_w - opc_w)) & mask;
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, strobes the instruction RAM and holds
// one fetched word for the decoder behind a valid/ready handshake.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int               ADDR_W   = 16,
    parameter int               DATA_W   = 16,
    parameter int               PC_INC   = 1,
    parameter int               OPC_W    = OPC_W_DEF,
    parameter logic [OPC_W-1:0] HALT_OPC = HALT_OPC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_target,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [DATA_W-1:0] ram_data,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic              busy,
    output logic              halted
);

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [DATA_W-1:0] ir_reg, ir_next;
    logic [ADDR_W-1:0] ir_pc_reg, ir_pc_next;
    logic              ir_valid_reg, ir_valid_next;

    logic [31:0]       ram_opc;
    logic              is_halt_word;
    logic              fetch_rd;

    assign ram_opc      = opcode_field(32'(ram_data), DATA_W, OPC_W);
    assign is_halt_word = (ram_opc == 32'(HALT_OPC));

    // A read is only issued when the instruction register has room this edge.
    assign fetch_rd = (state_reg == ST_FETCH) && (!ir_valid_reg || ir_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            pc_reg       <= '0;
            ir_reg       <= '0;
            ir_pc_reg    <= '0;
            ir_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            ir_reg       <= ir_next;
            ir_pc_reg    <= ir_pc_next;
            ir_valid_reg <= ir_valid_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        ir_next       = ir_reg;
        ir_pc_next    = ir_pc_reg;
        ir_valid_next = ir_valid_reg;

        case (state_reg)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    pc_next       = start_pc;
                    ir_valid_next = 1'b0;
                    state_next    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Redirect flushes the register, even a word accepted this edge.
                if (pc_load) begin
                    pc_next       = pc_target;
                    ir_valid_next = 1'b0;
                end else if (fetch_rd) begin
                    ir_next       = ram_data;
                    ir_pc_next    = pc_reg;
                    ir_valid_next = 1'b1;
                    if (is_halt_word) begin
                        state_next = ST_DRAIN;
                    end else begin
                        pc_next = pc_reg + ADDR_W'(PC_INC);
                    end
                end else if (ir_valid_reg && ir_ready) begin
                    ir_valid_next = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (ir_valid_reg && ir_ready) begin
                    ir_valid_next = 1'b0;
                    state_next    = ST_HALT;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign ram_addr = pc_reg;
    assign ram_rd   = fetch_rd;
    assign ir       = ir_reg;
    assign ir_pc    = ir_pc_reg;
    assign ir_valid = ir_valid_reg;
    assign busy     = (state_reg == ST_FETCH) || (state_reg == ST_DRAIN);
    assign halted   = (state_reg == ST_HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a behavioural fetch model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] start_pc = '0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_target = '0;
    logic [15:0] ram_addr;
    logic        ram_rd;
    logic [15:0] ram_data;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic        busy;
    logic        halted;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .start_pc  (start_pc),
        .pc_load   (pc_load),
        .pc_target (pc_target),
        .ram_addr  (ram_addr),
        .ram_rd    (ram_rd),
        .ram_data  (ram_data),
        .ir        (ir),
        .ir_pc     (ir_pc),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .busy      (busy),
        .halted    (halted)
    );

    function automatic logic [15:0] mem(input logic [15:0] a);
        if (a == 16'h0020) return 16'hF000;
        if (a == 16'hFFFF) return 16'h0ABC;
        return 16'h0100 + a;
    endfunction

    assign ram_data = mem(ram_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: 0 idle, 1 fetching, 2 waiting for halt word to drain, 3 halted.
    int          m_mode;
    logic [15:0] m_pc, m_ir, m_ir_pc;
    logic        m_valid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_pc = '0; m_ir = '0; m_ir_pc = '0; m_valid = 1'b0;
        end else begin
            if (m_mode == 0 || m_mode == 3) begin
                if (start) begin
                    m_pc = start_pc; m_valid = 1'b0; m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (pc_load) begin
                    m_pc = pc_target; m_valid = 1'b0;
                end else if (!m_valid || ir_ready) begin
                    m_ir = mem(m_pc); m_ir_pc = m_pc; m_valid = 1'b1;
                    if (m_ir[15:12] == 4'hF) m_mode = 2;
                    else m_pc = m_pc + 16'd1;
                end
            end else if (m_valid && ir_ready) begin
                m_valid = 1'b0; m_mode = 3;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_ram_addr", 32'(ram_addr), 32'(m_pc));
            chk("m_ram_rd", 32'(ram_rd), 32'((m_mode == 1) && (!m_valid || ir_ready)));
            chk("m_ir", 32'(ir), 32'(m_ir));
            chk("m_ir_pc", 32'(ir_pc), 32'(m_ir_pc));
            chk("m_ir_valid", 32'(ir_valid), 32'(m_valid));
            chk("m_busy", 32'(busy), 32'(m_mode == 1 || m_mode == 2));
            chk("m_halted", 32'(halted), 32'(m_mode == 3));
            if (ir_valid && ir_ready)
                $display("xfer ir_pc=%h ir=%h", ir_pc, ir);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ir(input logic [15:0] val, input int max);
        int n;
        n = 0;
        while (ir !== val && n < max) begin
            step();
            n++;
        end
        chk("wait_ir_reached", 32'(ir), 32'(val));
    endtask

    initial begin
        // Reset values
        step(); step();
        chk("rst_ram_addr", 32'(ram_addr), 32'h0);
        chk("rst_ram_rd", 32'(ram_rd), 32'h0);
        chk("rst_ir_valid", 32'(ir_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        rst_n = 1'b1;
        step();

        // Start at 0x10 with decoder stalled, then release and run to halt
        start = 1'b1; start_pc = 16'h0010; ir_ready = 1'b0;
        step();
        start = 1'b0;
        chk("start_addr", 32'(ram_addr), 32'h10);
        chk("start_rd", 32'(ram_rd), 32'h1);
        step();
        chk("first_ir", 32'(ir), 32'h0110);
        chk("first_ir_pc", 32'(ir_pc), 32'h10);
        for (int i = 0; i < 3; i++) begin
            chk("stall_ir", 32'(ir), 32'h0110);
            chk("stall_pc", 32'(ram_addr), 32'h11);
            chk("stall_rd", 32'(ram_rd), 32'h0);
            step();
        end
        ir_ready = 1'b1;
        step();
        chk("release_ir", 32'(ir), 32'h0111);
        wait_ir(16'hF000, 40);
        chk("halt_word_pc", 32'(ir_pc), 32'h20);
        chk("drain_rd", 32'(ram_rd), 32'h0);
        chk("drain_halted", 32'(halted), 32'h0);
        chk("drain_busy", 32'(busy), 32'h1);
        step();
        chk("halted", 32'(halted), 32'h1);
        chk("halted_valid", 32'(ir_valid), 32'h0);

        // Redirect while fetching 0x12
        start = 1'b1; start_pc = 16'h0010;
        step();
        start = 1'b0;
        step(); step();
        chk("pre_redirect_addr", 32'(ram_addr), 32'h12);
        pc_load = 1'b1; pc_target = 16'h0005;
        step();
        pc_load = 1'b0;
        chk("redirect_flush", 32'(ir_valid), 32'h0);
        chk("redirect_addr", 32'(ram_addr), 32'h05);
        step();
        chk("redirect_ir", 32'(ir), 32'h0105);
        chk("redirect_ir_pc", 32'(ir_pc), 32'h05);

        // Redirect coinciding with a halt word on the RAM bus
        pc_load = 1'b1; pc_target = 16'h0020;
        step();
        pc_target = 16'h0030;
        chk("halt_on_bus", 32'(ram_data), 32'hF000);
        step();
        pc_load = 1'b0;
        chk("collide_busy", 32'(busy), 32'h1);
        chk("collide_addr", 32'(ram_addr), 32'h30);
        step();
        chk("collide_ir", 32'(ir), 32'h0130);

        // start is ignored while fetching
        start = 1'b1; start_pc = 16'h0050;
        step();
        start = 1'b0;
        chk("ignored_start_addr", 32'(ram_addr), 32'h32);
        pc_load = 1'b1; pc_target = 16'h001E;
        step();
        pc_load = 1'b0;
        wait_ir(16'hF000, 10);
        step();
        chk("halted2", 32'(halted), 32'h1);

        // PC wrap at the top of the address space
        start = 1'b1; start_pc = 16'hFFFF;
        step();
        start = 1'b0;
        step();
        chk("wrap_ir", 32'(ir), 32'h0ABC);
        chk("wrap_ir_pc", 32'(ir_pc), 32'hFFFF);
        step();
        chk("wrapped_ir", 32'(ir), 32'h0100);
        chk("wrapped_ir_pc", 32'(ir_pc), 32'h0000);

        // Asynchronous reset mid-fetch
        chk("pre_reset_valid", 32'(ir_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_ram_addr", 32'(ram_addr), 32'h0);
        chk("arst_ram_rd", 32'(ram_rd), 32'h0);
        chk("arst_ir", 32'(ir), 32'h0);
        chk("arst_ir_pc", 32'(ir_pc), 32'h0);
        chk("arst_valid", 32'(ir_valid), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        step();
        rst_n = 1'b1;
        start = 1'b1; start_pc = 16'h0010;
        step();
        start = 1'b0;
        step();
        chk("resume_ir", 32'(ir), 32'h0110);
        step();
        chk("resume_ir2", 32'(ir), 32'h0111);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
